// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller for the MEM stage.
// Refills whole lines word by word over a ready-handshaked main-memory port.
module dcache_controller #(
    parameter int NUM_LINES       = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int ADDR_W          = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writeData,
    output logic [31:0]       readData,
    output logic              hit,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memWriteData,
    input  logic [31:0]       memReadData,
    input  logic              memReady
);

    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [OFF_W-1:0]       cnt_q, cnt_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]       lat_tag_q, lat_tag_d;
    logic [IDX_W-1:0]       lat_idx_q, lat_idx_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [31:0]            mem_wdata_q, mem_wdata_d;
    logic [31:0]            read_data_q, read_data_d;

    logic [31:0]            data_q [NUM_LINES*WORDS_PER_BLOCK];
    logic [TAG_W-1:0]       tag_q  [NUM_LINES];

    logic [TAG_W-1:0]       addr_tag_s;
    logic [IDX_W-1:0]       addr_idx_s;
    logic [OFF_W-1:0]       addr_off_s;
    logic                   lookup_hit_s;
    logic [31:0]            cached_word_s;
    logic [OFF_W-1:0]       cnt_inc_s;

    logic                   hit_s;
    logic [31:0]            read_data_s;
    logic                   data_we_s;
    logic [IDX_W+OFF_W-1:0] data_waddr_s;
    logic [31:0]            data_wdata_s;
    logic                   tag_we_s;
    logic                   unused_s;

    assign addr_tag_s    = address[ADDR_W-1 -: TAG_W];
    assign addr_idx_s    = address[2+OFF_W +: IDX_W];
    assign addr_off_s    = address[2 +: OFF_W];
    assign lookup_hit_s  = valid_q[addr_idx_s] && (tag_q[addr_idx_s] == addr_tag_s);
    assign cached_word_s = data_q[{addr_idx_s, addr_off_s}];
    assign cnt_inc_s     = cnt_q + {{(OFF_W-1){1'b0}}, 1'b1};
    assign unused_s      = ^address[1:0];

    // Next-state, stall and storage-write decode for the controller FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        valid_d      = valid_q;
        lat_tag_d    = lat_tag_q;
        lat_idx_d    = lat_idx_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        read_data_d  = read_data_q;
        hit_s        = 1'b1;
        read_data_s  = read_data_q;
        data_we_s    = 1'b0;
        data_waddr_s = {addr_idx_s, addr_off_s};
        data_wdata_s = writeData;
        tag_we_s     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A write wins over a simultaneous read.
                if (memWrite) begin
                    hit_s       = 1'b0;
                    state_d     = S_WRITE;
                    lat_tag_d   = addr_tag_s;
                    lat_idx_d   = addr_idx_s;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {address[ADDR_W-1:2], 2'b00};
                    mem_wdata_d = writeData;
                    if (lookup_hit_s) begin
                        data_we_s = 1'b1;
                    end else begin
                        data_we_s = 1'b0;
                    end
                end else if (memRead) begin
                    if (lookup_hit_s) begin
                        read_data_s = cached_word_s;
                        read_data_d = cached_word_s;
                    end else begin
                        hit_s      = 1'b0;
                        state_d    = S_REFILL;
                        cnt_d      = {OFF_W{1'b0}};
                        lat_tag_d  = addr_tag_s;
                        lat_idx_d  = addr_idx_s;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {addr_tag_s, addr_idx_s, {OFF_W{1'b0}}, 2'b00};
                    end
                end else begin
                    hit_s = 1'b1;
                end
            end
            S_REFILL: begin
                hit_s        = 1'b0;
                data_waddr_s = {lat_idx_q, cnt_q};
                data_wdata_s = memReadData;
                if (memReady) begin
                    data_we_s = 1'b1;
                    if (cnt_q == {OFF_W{1'b1}}) begin
                        valid_d[lat_idx_q] = 1'b1;
                        tag_we_s           = 1'b1;
                        state_d            = S_IDLE;
                        cnt_d              = {OFF_W{1'b0}};
                        mem_req_d          = 1'b0;
                        mem_we_d           = 1'b0;
                    end else begin
                        cnt_d      = cnt_inc_s;
                        mem_addr_d = {lat_tag_q, lat_idx_q, cnt_inc_s, 2'b00};
                    end
                end else begin
                    data_we_s = 1'b0;
                end
            end
            S_WRITE: begin
                hit_s = 1'b0;
                if (memReady) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_DONE: begin
                // One hit cycle so the pipeline retires the store instead of re-issuing it.
                hit_s   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // Controller state and registered memory-side outputs; reset drops any partial refill.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= {OFF_W{1'b0}};
            valid_q     <= {NUM_LINES{1'b0}};
            lat_tag_q   <= {TAG_W{1'b0}};
            lat_idx_q   <= {IDX_W{1'b0}};
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= 32'h0000_0000;
            read_data_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            lat_tag_q   <= lat_tag_d;
            lat_idx_q   <= lat_idx_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            read_data_q <= read_data_d;
        end
    end

    // Line data storage; contents are only meaningful behind a set valid bit.
    always_ff @(posedge clock) begin
        if (data_we_s) begin
            data_q[data_waddr_s] <= data_wdata_s;
        end
    end

    // Tag storage, written when the last word of a refill lands.
    always_ff @(posedge clock) begin
        if (tag_we_s) begin
            tag_q[lat_idx_q] <= lat_tag_q;
        end
    end

    assign hit          = hit_s;
    assign readData     = read_data_s;
    assign memReq       = mem_req_q;
    assign memWe        = mem_we_q;
    assign memAddr      = mem_addr_q;
    assign memWriteData = mem_wdata_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: a delayed-ready memory responder plus
// hand-computed load/store scenarios covering refill, hits, write-through, conflict and reset.
module tb_dcache_controller;

    logic        clock;
    logic        reset;
    logic        memRead;
    logic        memWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        hit;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;
    logic        memReady;

    int n_cmp = 0;
    int n_err = 0;
    logic        pend;
    logic [31:0] log_addr [$];
    logic        log_we   [$];
    logic [31:0] log_wd   [$];

    dcache_controller dut (
        .clock        (clock),
        .reset        (reset),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .address      (address),
        .writeData    (writeData),
        .readData     (readData),
        .hit          (hit),
        .memReq       (memReq),
        .memWe        (memWe),
        .memAddr      (memAddr),
        .memWriteData (memWriteData),
        .memReadData  (memReadData),
        .memReady     (memReady)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: ready one cycle after a request is seen, one-cycle pulse, word = {C0DE, addr[15:0]}.
    initial begin
        memReady    = 1'b0;
        memReadData = 32'h0000_0000;
        pend        = 1'b0;
        forever begin
            @(negedge clock);
            if (memReady) begin
                memReady = 1'b0;
                pend     = 1'b0;
            end else if (memReq) begin
                if (pend) begin
                    memReady    = 1'b1;
                    memReadData = {16'hC0DE, memAddr[15:0]};
                    log_addr.push_back(memAddr);
                    log_we.push_back(memWe);
                    log_wd.push_back(memWriteData);
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                end
            end else begin
                pend = 1'b0;
            end
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_we.delete();
        log_wd.delete();
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic exp_miss,
                           input logic [31:0] exp_data, input int exp_cycles);
        int   cycles;
        logic first_hit;
        clear_log();
        @(negedge clock);
        memRead  = 1'b1;
        memWrite = 1'b0;
        address  = a;
        #1;
        first_hit = hit;
        check_eq({tag, "_first_hit"}, {31'd0, first_hit}, {31'd0, ~exp_miss});
        if (!exp_miss) check_eq({tag, "_memreq_idle"}, {31'd0, memReq}, 32'd0);
        cycles = 0;
        while (!hit && cycles < 200) begin
            @(negedge clock);
            #1;
            cycles++;
        end
        check_eq({tag, "_done"}, {31'd0, hit}, 32'd1);
        check_eq({tag, "_data"}, readData, exp_data);
        if (exp_cycles > 0) check_eq({tag, "_stall_cycles"}, cycles, exp_cycles);
        memRead = 1'b0;
        if (exp_miss) begin
            check_eq({tag, "_nwords"}, log_addr.size(), 32'd4);
            for (int i = 0; i < log_addr.size() && i < 4; i++) begin
                check_eq({tag, "_raddr"}, log_addr[i], {a[31:4], 4'h0} + 32'(4 * i));
                check_eq({tag, "_rwe"}, {31'd0, log_we[i]}, 32'd0);
            end
        end else begin
            check_eq({tag, "_nomem"}, log_addr.size(), 32'd0);
        end
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic also_read);
        int cycles;
        clear_log();
        @(negedge clock);
        memWrite  = 1'b1;
        memRead   = also_read;
        address   = a;
        writeData = d;
        #1;
        check_eq({tag, "_entry_hit"}, {31'd0, hit}, 32'd0);
        @(negedge clock);
        #1;
        check_eq({tag, "_req"}, {31'd0, memReq}, 32'd1);
        check_eq({tag, "_we"}, {31'd0, memWe}, 32'd1);
        check_eq({tag, "_addr"}, memAddr, {a[31:2], 2'b00});
        check_eq({tag, "_wdata"}, memWriteData, d);
        check_eq({tag, "_wr_hit"}, {31'd0, hit}, 32'd0);
        cycles = 0;
        while (!hit && cycles < 200) begin
            @(negedge clock);
            #1;
            cycles++;
        end
        check_eq({tag, "_done_hit"}, {31'd0, hit}, 32'd1);
        check_eq({tag, "_done_req"}, {31'd0, memReq}, 32'd0);
        memWrite = 1'b0;
        memRead  = 1'b0;
        check_eq({tag, "_ntx"}, log_addr.size(), 32'd1);
        if (log_addr.size() == 1) begin
            check_eq({tag, "_log_we"}, {31'd0, log_we[0]}, 32'd1);
            check_eq({tag, "_log_addr"}, log_addr[0], {a[31:2], 2'b00});
            check_eq({tag, "_log_wd"}, log_wd[0], d);
        end
    endtask

    initial begin
        int guard;
        reset     = 1'b1;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        address   = 32'h0000_0000;
        writeData = 32'h0000_0000;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("rst_hit", {31'd0, hit}, 32'd1);
        check_eq("rst_req", {31'd0, memReq}, 32'd0);
        check_eq("rst_we", {31'd0, memWe}, 32'd0);
        check_eq("rst_addr", memAddr, 32'h0000_0000);
        check_eq("rst_wdata", memWriteData, 32'h0000_0000);
        check_eq("rst_rdata", readData, 32'h0000_0000);

        do_read("t1_miss40", 32'h0000_0040, 1'b1, 32'hC0DE_0040, 12);
        do_read("t2_hit48", 32'h0000_0048, 1'b0, 32'hC0DE_0048, 0);

        do_write("t3_st44", 32'h0000_0044, 32'hDEAD_BEEF, 1'b0);
        do_read("t3_hit44", 32'h0000_0044, 1'b0, 32'hDEAD_BEEF, 0);
        do_write("t3_st1000", 32'h0000_1000, 32'hCAFE_F00D, 1'b0);
        do_read("t3_miss1000", 32'h0000_1000, 1'b1, 32'hC0DE_1000, 12);

        do_read("t4_miss240", 32'h0000_0240, 1'b1, 32'hC0DE_0240, 12);
        do_read("t4_miss40", 32'h0000_0040, 1'b1, 32'hC0DE_0040, 12);

        // Reset right after the second refill word of line 0x80 has been accepted.
        clear_log();
        @(negedge clock);
        memRead = 1'b1;
        address = 32'h0000_0080;
        guard   = 0;
        while (log_addr.size() < 2 && guard < 100) begin
            @(negedge clock);
            #1;
            guard++;
        end
        check_eq("t5_two_words", log_addr.size(), 32'd2);
        @(negedge clock);
        reset   = 1'b1;
        memRead = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("t5_rst_req", {31'd0, memReq}, 32'd0);
        check_eq("t5_rst_hit", {31'd0, hit}, 32'd1);
        check_eq("t5_rst_rdata", readData, 32'h0000_0000);
        do_read("t5_miss80", 32'h0000_0080, 1'b1, 32'hC0DE_0080, 12);

        do_write("t6_rdwr40", 32'h0000_0040, 32'h1234_5678, 1'b1);
        do_read("t6_miss40", 32'h0000_0040, 1'b1, 32'hC0DE_0040, 12);
        do_read("t6_hit80", 32'h0000_008C, 1'b0, 32'hC0DE_008C, 0);

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
